// File: rtl/burst_ram_arbiter_pkg.sv
// Shared types and constants for the burst RAM arbiter.
package burst_ram_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_CMD        = 3'd1,
      ST_WR_DATA    = 3'd2,
      ST_RD_COLLECT = 3'd3,
      ST_DONE       = 3'd4
   } state_e;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/burst_ram_arbiter.sv
// Burst RAM arbiter: grants one of two cache-line requesters, issues one burst
// command per line, serializes write lines and gathers read words into a line.
// Optional macro BURST_RAM_ARBITER_ROUND_ROBIN_EN: alternate grants on contest;
// without it port 0 has fixed priority.
module burst_ram_arbiter
   import burst_ram_arbiter_pkg::*;
#(
   parameter int DataBitWidth    = 64,
   parameter int AddressBitWidth = 4,
   parameter int BurstDataCount  = 4,
   localparam int LineAddressBitWidth = AddressBitWidth - $clog2(BurstDataCount),
   localparam int LineBitWidth        = DataBitWidth * BurstDataCount
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req0_en,
   input  logic                           req0_cmd,
   input  logic [LineAddressBitWidth-1:0] req0_addr,
   input  logic [LineBitWidth-1:0]        req0_wr_line,
   output logic [LineBitWidth-1:0]        req0_rd_line,
   output logic                           req0_done,
   input  logic                           req1_en,
   input  logic                           req1_cmd,
   input  logic [LineAddressBitWidth-1:0] req1_addr,
   input  logic [LineBitWidth-1:0]        req1_wr_line,
   output logic [LineBitWidth-1:0]        req1_rd_line,
   output logic                           req1_done,
   output logic                           ram_cmd,
   output logic                           ram_cmd_en,
   output logic [AddressBitWidth-1:0]     ram_addr,
   output logic [DataBitWidth-1:0]        ram_wr_data,
   output logic [DataBitWidth/8-1:0]      ram_data_mask,
   input  logic [DataBitWidth-1:0]        ram_rd_data,
   input  logic                           ram_rd_data_valid,
   input  logic                           ram_init_calib,
   input  logic                           ram_busy
);

   localparam int IdxW = $clog2(BurstDataCount);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(BurstDataCount - 1);

   state_e                         state_q, state_d;
   logic                           grant_q, grant_d;
   logic                           cmd_q, cmd_d;
   logic [LineAddressBitWidth-1:0] addr_q, addr_d;
   logic [LineBitWidth-1:0]        wr_line_q, wr_line_d;
   logic [IdxW-1:0]                idx_q, idx_d;
   logic [LineBitWidth-1:0]        rd_buf_q, rd_buf_d;
   logic                           ram_cmd_en_q, ram_cmd_en_d;
   logic                           ram_cmd_q, ram_cmd_d;
   logic [AddressBitWidth-1:0]     ram_addr_q, ram_addr_d;
   logic [DataBitWidth-1:0]        ram_wr_data_q, ram_wr_data_d;
   logic                           done0_q, done0_d;
   logic                           done1_q, done1_d;
   logic [LineBitWidth-1:0]        rd_line0_q, rd_line0_d;
   logic [LineBitWidth-1:0]        rd_line1_q, rd_line1_d;
`ifdef BURST_RAM_ARBITER_ROUND_ROBIN_EN
   logic                           last_grant_q, last_grant_d;
`endif

   logic                           grant_ok_s;
   logic                           sel_s;
   logic                           sel_cmd_s;
   logic [LineAddressBitWidth-1:0] sel_addr_s;
   logic [LineBitWidth-1:0]        sel_line_s;
   logic [IdxW-1:0]                idx_inc_s;

`ifdef BURST_RAM_ARBITER_ROUND_ROBIN_EN
   // On a contest, hand the RAM to the port that did not win last time.
   function automatic logic pick_grant(input logic en0, input logic en1, input logic last);
      logic g;
      if (en0 && en1) begin
         g = ~last;
      end else if (en1) begin
         g = 1'b1;
      end else begin
         g = 1'b0;
      end
      return g;
   endfunction
   assign sel_s = pick_grant(req0_en, req1_en, last_grant_q);
`else
   // Fixed priority: port 0 wins any contest.
   function automatic logic pick_grant(input logic en0, input logic en1);
      logic g;
      if (en0) begin
         g = 1'b0;
      end else if (en1) begin
         g = 1'b1;
      end else begin
         g = 1'b0;
      end
      return g;
   endfunction
   assign sel_s = pick_grant(req0_en, req1_en);
`endif

   assign grant_ok_s    = ram_init_calib && !ram_busy && (req0_en || req1_en);
   assign sel_cmd_s     = sel_s ? req1_cmd : req0_cmd;
   assign sel_addr_s    = sel_s ? req1_addr : req0_addr;
   assign sel_line_s    = sel_s ? req1_wr_line : req0_wr_line;
   assign idx_inc_s     = idx_q + IdxW'(1);
   assign ram_data_mask = {(DataBitWidth/8){1'b0}};

   assign ram_cmd      = ram_cmd_q;
   assign ram_cmd_en   = ram_cmd_en_q;
   assign ram_addr     = ram_addr_q;
   assign ram_wr_data  = ram_wr_data_q;
   assign req0_done    = done0_q;
   assign req1_done    = done1_q;
   assign req0_rd_line = rd_line0_q;
   assign req1_rd_line = rd_line1_q;

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         grant_q       <= 1'b0;
         cmd_q         <= CMD_READ;
         addr_q        <= '0;
         wr_line_q     <= '0;
         idx_q         <= '0;
         rd_buf_q      <= '0;
         ram_cmd_en_q  <= 1'b0;
         ram_cmd_q     <= 1'b0;
         ram_addr_q    <= '0;
         ram_wr_data_q <= '0;
         done0_q       <= 1'b0;
         done1_q       <= 1'b0;
         rd_line0_q    <= '0;
         rd_line1_q    <= '0;
`ifdef BURST_RAM_ARBITER_ROUND_ROBIN_EN
         last_grant_q  <= 1'b1;
`endif
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         cmd_q         <= cmd_d;
         addr_q        <= addr_d;
         wr_line_q     <= wr_line_d;
         idx_q         <= idx_d;
         rd_buf_q      <= rd_buf_d;
         ram_cmd_en_q  <= ram_cmd_en_d;
         ram_cmd_q     <= ram_cmd_d;
         ram_addr_q    <= ram_addr_d;
         ram_wr_data_q <= ram_wr_data_d;
         done0_q       <= done0_d;
         done1_q       <= done1_d;
         rd_line0_q    <= rd_line0_d;
         rd_line1_q    <= rd_line1_d;
`ifdef BURST_RAM_ARBITER_ROUND_ROBIN_EN
         last_grant_q  <= last_grant_d;
`endif
      end
   end

   // Next-state logic of the burst sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_ok_s) begin
               state_d = ST_CMD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CMD: begin
            if (cmd_q == CMD_WRITE) begin
               state_d = ST_WR_DATA;
            end else begin
               state_d = ST_RD_COLLECT;
            end
         end
         ST_WR_DATA: begin
            if (idx_q == IdxLast) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_WR_DATA;
            end
         end
         ST_RD_COLLECT: begin
            if (ram_rd_data_valid && (idx_q == IdxLast)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RD_COLLECT;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next values; outputs are prepared one cycle ahead so
   // that the registered value lines up with the state it belongs to.
   always_comb begin
      grant_d       = grant_q;
      cmd_d         = cmd_q;
      addr_d        = addr_q;
      wr_line_d     = wr_line_q;
      idx_d         = idx_q;
      rd_buf_d      = rd_buf_q;
      ram_cmd_en_d  = 1'b0;
      ram_cmd_d     = ram_cmd_q;
      ram_addr_d    = ram_addr_q;
      ram_wr_data_d = ram_wr_data_q;
      rd_line0_d    = rd_line0_q;
      rd_line1_d    = rd_line1_q;
`ifdef BURST_RAM_ARBITER_ROUND_ROBIN_EN
      last_grant_d  = last_grant_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (grant_ok_s) begin
               grant_d      = sel_s;
               cmd_d        = sel_cmd_s;
               addr_d       = sel_addr_s;
               wr_line_d    = sel_line_s;
               idx_d        = '0;
               ram_cmd_en_d = 1'b1;
               ram_cmd_d    = sel_cmd_s;
               ram_addr_d   = {sel_addr_s, {IdxW{1'b0}}};
`ifdef BURST_RAM_ARBITER_ROUND_ROBIN_EN
               last_grant_d = sel_s;
`endif
               if (sel_cmd_s == CMD_WRITE) begin
                  ram_wr_data_d = sel_line_s[DataBitWidth-1:0];
               end else begin
                  ram_wr_data_d = ram_wr_data_q;
               end
            end else begin
               idx_d = idx_q;
            end
         end
         ST_CMD: begin
            if (cmd_q == CMD_WRITE) begin
               ram_wr_data_d = wr_line_q[idx_inc_s*DataBitWidth +: DataBitWidth];
               idx_d         = IdxW'(1);
            end else begin
               idx_d = '0;
            end
         end
         ST_WR_DATA: begin
            idx_d = idx_inc_s;
            if (idx_q != IdxLast) begin
               ram_wr_data_d = wr_line_q[idx_inc_s*DataBitWidth +: DataBitWidth];
            end else begin
               ram_wr_data_d = ram_wr_data_q;
            end
         end
         ST_RD_COLLECT: begin
            if (ram_rd_data_valid) begin
               rd_buf_d[idx_q*DataBitWidth +: DataBitWidth] = ram_rd_data;
               idx_d = idx_inc_s;
               if (idx_q == IdxLast) begin
                  if (grant_q) begin
                     rd_line1_d = rd_buf_d;
                  end else begin
                     rd_line0_d = rd_buf_d;
                  end
               end else begin
                  rd_line0_d = rd_line0_q;
               end
            end else begin
               idx_d = idx_q;
            end
         end
         ST_DONE: idx_d = '0;
         default: idx_d = '0;
      endcase
      done0_d = (state_d == ST_DONE) && !grant_q;
      done1_d = (state_d == ST_DONE) && grant_q;
   end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed testbench for burst_ram_arbiter with a small burst RAM model
// (4-word bursts, first read word 6 cycles after the command, one idle gap).
module tb_burst_ram_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_en, req0_cmd, req1_en, req1_cmd;
   logic [1:0]   req0_addr, req1_addr;
   logic [255:0] req0_wr_line, req1_wr_line, req0_rd_line, req1_rd_line;
   logic         req0_done, req1_done;
   logic         ram_cmd, ram_cmd_en;
   logic [3:0]   ram_addr;
   logic [63:0]  ram_wr_data;
   logic [7:0]   ram_data_mask;
   logic [63:0]  ram_rd_data = 64'd0;
   logic         ram_rd_data_valid = 1'b0;
   logic         ram_init_calib, ram_busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] mem [16];
   int wr_left = 0, rd_step = 0, rd_sent = 0;
   logic [3:0] wr_addr = 4'd0, rd_addr = 4'd0;
   bit rd_active = 1'b0;

   burst_ram_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_en(req0_en), .req0_cmd(req0_cmd), .req0_addr(req0_addr),
      .req0_wr_line(req0_wr_line), .req0_rd_line(req0_rd_line), .req0_done(req0_done),
      .req1_en(req1_en), .req1_cmd(req1_cmd), .req1_addr(req1_addr),
      .req1_wr_line(req1_wr_line), .req1_rd_line(req1_rd_line), .req1_done(req1_done),
      .ram_cmd(ram_cmd), .ram_cmd_en(ram_cmd_en), .ram_addr(ram_addr),
      .ram_wr_data(ram_wr_data), .ram_data_mask(ram_data_mask),
      .ram_rd_data(ram_rd_data), .ram_rd_data_valid(ram_rd_data_valid),
      .ram_init_calib(ram_init_calib), .ram_busy(ram_busy)
   );

   always #5 clk = ~clk;

   // Burst RAM model, acting on the falling edge where DUT outputs are stable.
   always @(negedge clk) begin
      if (rst) begin
         wr_left = 0; rd_active = 1'b0; rd_sent = 0; ram_rd_data_valid = 1'b0;
      end else begin
         ram_rd_data_valid = 1'b0;
         if (wr_left != 0) begin
            mem[wr_addr] = ram_wr_data; wr_addr = wr_addr + 4'd1; wr_left = wr_left - 1;
         end else if (ram_cmd_en && ram_cmd) begin
            mem[ram_addr] = ram_wr_data; wr_addr = ram_addr + 4'd1; wr_left = 3;
         end
         if (rd_active) begin
            rd_step = rd_step + 1;
            if (rd_step == 6 || rd_step == 7 || rd_step == 9 || rd_step == 10) begin
               ram_rd_data_valid = 1'b1;
               ram_rd_data = mem[rd_addr + 4'(rd_sent)];
               rd_sent = rd_sent + 1;
               if (rd_sent == 4) rd_active = 1'b0;
            end
         end else if (ram_cmd_en && !ram_cmd) begin
            rd_active = 1'b1; rd_step = 0; rd_sent = 0; rd_addr = ram_addr;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait up to max_cyc falling edges for ram_cmd_en.
   task automatic wait_cmd(input int max_cyc);
      bit seen = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (ram_cmd_en) begin seen = 1'b1; break; end
      end
      check_eq("cmd_timeout", 256'(seen), 256'd1);
   endtask

   // Wait up to max_cyc falling edges for any done; report latency and port.
   task automatic wait_done(input int max_cyc, output int lat, output int port);
      lat = -1; port = -1;
      for (int i = 1; i <= max_cyc; i++) begin
         @(negedge clk);
         if (req0_done || req1_done) begin
            lat = i; port = req1_done ? 1 : 0; break;
         end
      end
      check_eq("done_timeout", 256'(lat > 0), 256'd1);
   endtask

   localparam logic [255:0] LINE_A = {64'h44, 64'h33, 64'h22, 64'h11};
   localparam logic [255:0] LINE_0 = {64'h1003, 64'h1002, 64'h1001, 64'h1000};
   localparam logic [255:0] LINE_B = {64'h88, 64'h77, 64'h66, 64'h55};

   initial begin
      int lat, port, cnt;
      int order [4];
      bit seen;
      for (int k = 0; k < 16; k++) mem[k] = 64'h1000 + 64'(k);
      rst = 1'b1; ram_init_calib = 1'b0; ram_busy = 1'b0;
      req0_en = 1'b0; req0_cmd = 1'b0; req0_addr = 2'd0; req0_wr_line = '0;
      req1_en = 1'b0; req1_cmd = 1'b0; req1_addr = 2'd0; req1_wr_line = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_cmd_en", 256'(ram_cmd_en), 256'd0);
      check_eq("rst_cmd", 256'(ram_cmd), 256'd0);
      check_eq("rst_addr", 256'(ram_addr), 256'd0);
      check_eq("rst_wr_data", 256'(ram_wr_data), 256'd0);
      check_eq("rst_done", 256'({req1_done, req0_done}), 256'd0);
      check_eq("rst_rd_line0", req0_rd_line, 256'd0);
      check_eq("rst_rd_line1", req1_rd_line, 256'd0);
      check_eq("data_mask", 256'(ram_data_mask), 256'd0);

      // Write line 1 from port 0; nothing may happen before calibration.
      req0_addr = 2'd1; req0_cmd = 1'b1; req0_wr_line = LINE_A; req0_en = 1'b1;
      cnt = 0;
      repeat (8) begin @(negedge clk); if (ram_cmd_en) cnt++; end
      check_eq("no_grant_uncal", 256'(cnt), 256'd0);
      ram_init_calib = 1'b1;
      wait_cmd(20);
      check_eq("wr_addr", 256'(ram_addr), 256'd4);
      check_eq("wr_cmd", 256'(ram_cmd), 256'd1);
      check_eq("wr_word0", 256'(ram_wr_data), 256'h11);
      wait_done(20, lat, port);
      check_eq("wr_latency", 256'(lat), 256'd4);
      check_eq("wr_port", 256'(port), 256'd0);
      req0_en = 1'b0;
      @(negedge clk);
      check_eq("done0_single", 256'(req0_done), 256'd0);
      check_eq("ram_line1", {mem[7], mem[6], mem[5], mem[4]}, LINE_A);

      // Read line 1 from port 1.
      req1_addr = 2'd1; req1_cmd = 1'b0; req1_en = 1'b1;
      wait_done(40, lat, port);
      check_eq("rd_port", 256'(port), 256'd1);
      check_eq("rd_line1", req1_rd_line, LINE_A);
      check_eq("rd_line0_kept", req0_rd_line, 256'd0);
      req1_en = 1'b0;
      @(negedge clk);
      check_eq("done1_single", 256'(req1_done), 256'd0);

      // Both ports request reads continuously for four transactions.
      req0_addr = 2'd1; req0_cmd = 1'b0; req0_en = 1'b1;
      req1_addr = 2'd0; req1_cmd = 1'b0; req1_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_done(40, lat, port);
         order[i] = port;
         if (port == 1) check_eq("contest_rd1", req1_rd_line, LINE_0);
         else           check_eq("contest_rd0", req0_rd_line, LINE_A);
         if (i == 3) begin req0_en = 1'b0; req1_en = 1'b0; end
      end
`ifdef BURST_RAM_ARBITER_ROUND_ROBIN_EN
      check_eq("grant_order", 256'({order[0][1:0], order[1][1:0], order[2][1:0], order[3][1:0]}), 256'b00_01_00_01);
`else
      check_eq("grant_order", 256'({order[0][1:0], order[1][1:0], order[2][1:0], order[3][1:0]}), 256'b00_00_00_00);
`endif
      @(negedge clk);

      // Reset in the middle of a read burst, after two words were taken.
      req0_addr = 2'd0; req0_cmd = 1'b0; req0_en = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         if (rd_sent == 2) begin seen = 1'b1; break; end
      end
      check_eq("rd_two_words", 256'(seen), 256'd1);
      @(negedge clk);
      rst = 1'b1; req0_en = 1'b0;
      cnt = 0;
      repeat (2) begin @(negedge clk); if (req0_done || req1_done) cnt++; end
      rst = 1'b0;
      repeat (4) begin @(negedge clk); if (req0_done || req1_done || ram_cmd_en) cnt++; end
      check_eq("abort_no_done", 256'(cnt), 256'd0);
      check_eq("abort_rd_line0", req0_rd_line, 256'd0);
      req0_en = 1'b1;
      wait_done(40, lat, port);
      check_eq("reread_port", 256'(port), 256'd0);
      check_eq("reread_line0", req0_rd_line, LINE_0);
      req0_en = 1'b0;
      @(negedge clk);

      // RAM busy in Idle blocks the grant until released.
      ram_busy = 1'b1;
      req0_addr = 2'd2; req0_cmd = 1'b1; req0_wr_line = LINE_B; req0_en = 1'b1;
      cnt = 0;
      repeat (10) begin @(negedge clk); if (ram_cmd_en) cnt++; end
      check_eq("busy_blocks", 256'(cnt), 256'd0);
      ram_busy = 1'b0;
      @(negedge clk);
      check_eq("cmd_after_busy", 256'(ram_cmd_en), 256'd1);
      check_eq("busy_wr_addr", 256'(ram_addr), 256'd8);
      wait_done(20, lat, port);
      check_eq("busy_wr_latency", 256'(lat), 256'd4);
      req0_en = 1'b0;
      @(negedge clk);
      check_eq("ram_line2", {mem[11], mem[10], mem[9], mem[8]}, LINE_B);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
